// File: rtl/alu_result_pipe_pkg.sv
// Shared definitions for the registered ALU result pipe: opcode encodings,
// skid-buffer state encoding and the layout of the packed flag field.
package alu_result_pipe_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    // Flags stored alongside the result in each buffer entry,
    // packed as {zero, neg, carry, ovf, ill} below the result bits.
    localparam int FLAG_W = 5;

    // Occupancy of the two-entry output buffer (main register M, skid register S).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_result_pipe_core.sv
// Purely combinational ALU datapath: AND/OR/XOR/ADD/SUB/SLT/SLTU with result
// flags. Unknown opcodes produce a zero result and raise ill.
module alu_result_pipe_core
    import alu_result_pipe_pkg::*;
#(
    parameter int N   = 32,
    parameter int OPW = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [N-1:0]   res,
    output logic           zero,
    output logic           neg,
    output logic           carry,
    output logic           ovf,
    output logic           ill
);

    logic [N:0] sum;
    logic [N:0] diff;
    logic       slt;
    logic       sltu;

    // Subtraction is done as A + ~B + 1 so bit N reads as "no borrow".
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign slt  = ($signed(a) < $signed(b));
    assign sltu = (a < b);

    // Opcode decode; every output has a default so unlisted codes fall to ill.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        ill   = 1'b0;
        case (op)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_ADD: begin
                res   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                res   = diff[N-1:0];
                carry = diff[N];
                ovf   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            ALU_SLT:  res = {{(N-1){1'b0}}, slt};
            ALU_SLTU: res = {{(N-1){1'b0}}, sltu};
            default:  ill = 1'b1;
        endcase
    end

    assign zero = (res == '0);
    assign neg  = res[N-1];

endmodule

// File: rtl/alu_result_pipe.sv
// Registered ALU result stage with valid/ready on both sides and a two-entry
// skid buffer. M drives the outputs; S catches one extra result when the
// consumer stalls, which lets in_ready depend on buffer state alone.
module alu_result_pipe
    import alu_result_pipe_pkg::*;
#(
    parameter int N   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_res,
    output logic           out_zero,
    output logic           out_neg,
    output logic           out_carry,
    output logic           out_ovf,
    output logic           out_ill
);

    localparam int EW = N + FLAG_W;

    buf_state_t    state;
    buf_state_t    state_next;
    logic [N-1:0]  core_res;
    logic          core_zero;
    logic          core_neg;
    logic          core_carry;
    logic          core_ovf;
    logic          core_ill;
    logic [EW-1:0] core_entry;
    logic [EW-1:0] m_q;
    logic [EW-1:0] s_q;
    logic          in_xfer;
    logic          out_xfer;

    alu_result_pipe_core #(
        .N   (N),
        .OPW (OPW)
    ) u_core (
        .a     (in_a),
        .b     (in_b),
        .op    (in_op),
        .res   (core_res),
        .zero  (core_zero),
        .neg   (core_neg),
        .carry (core_carry),
        .ovf   (core_ovf),
        .ill   (core_ill)
    );

    assign core_entry = {core_res, core_zero, core_neg, core_carry, core_ovf, core_ill};
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;

    // Buffer occupancy register; reset discards whatever was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy moves up on an accept, down on a hand-off, and stays put when both happen.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) state_next = ST_ONE;
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_next = ST_FULL;
                else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_xfer) state_next = ST_ONE;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from occupancy only, never from out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_EMPTY: in_ready = !rst;
            ST_ONE: begin
                in_ready  = !rst;
                out_valid = 1'b1;
            end
            ST_FULL:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Entry storage: new results go to M when it is free or being drained, otherwise to S; S refills M in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) m_q <= core_entry;
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) m_q <= core_entry;
                    else if (in_xfer)        s_q <= core_entry;
                end
                ST_FULL: begin
                    if (out_xfer) m_q <= s_q;
                end
                default: begin
                    m_q <= m_q;
                end
            endcase
        end
    end

    assign {out_res, out_zero, out_neg, out_carry, out_ovf, out_ill} = m_q;

endmodule

// File: tb/tb_alu_result_pipe.sv
// Self-checking bench for alu_result_pipe (N=32): directed corner cases followed
// by a long randomized run against an arithmetic reference model and an
// in-order expectation queue.
module tb_alu_result_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
    logic        out_ovf;
    logic        out_ill;

    int          vectors     = 0;
    int          miscompares = 0;
    int          popCount    = 0;
    logic [36:0] expQ[$];
    logic        held        = 1'b0;
    logic [36:0] heldVal     = '0;

    alu_result_pipe #(
        .N   (32),
        .OPW (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_ill   (out_ill)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from the arithmetic definitions: returns {res, zero, neg, carry, ovf, ill}.
    function automatic logic [36:0] refAlu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        logic [31:0]     r;
        logic            c;
        logic            o;
        logic            il;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        sr = 0;
        r  = '0;
        c  = 1'b0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0010: begin
                r  = a + b;
                c  = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                sr = sa + sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: r = (a < b) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
        return {r, (r == 32'd0), r[31], c, o, il};
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] edgeVals[5];
        edgeVals = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) return edgeVals[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle check of handshake and data against the expectation queue.
    task automatic checkOutput();
        logic [36:0] got;
        got = {out_res, out_zero, out_neg, out_carry, out_ovf, out_ill};
        checkValue("out_valid", 64'(out_valid), 64'(expQ.size() != 0));
        checkValue("in_ready", 64'(in_ready), 64'(expQ.size() < 2));
        if (expQ.size() != 0) checkValue("result", 64'(got), 64'(expQ[0]));
        if (held) checkValue("hold", 64'(got), 64'(heldVal));
    endtask

    // One clock of stimulus: check at the falling edge, drive, then book the transfers the next rising edge will make.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic ordy, output logic acc);
        @(negedge clk);
        checkOutput();
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        #1;
        acc     = in_valid && in_ready;
        held    = out_valid && !out_ready;
        heldVal = {out_res, out_zero, out_neg, out_carry, out_ovf, out_ill};
        if (out_valid && out_ready && expQ.size() != 0) begin
            void'(expQ.pop_front());
            popCount++;
        end
        if (acc) expQ.push_back(refAlu(a, b, op));
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            checkValue("rst out_valid", 64'(out_valid), 64'(0));
            checkValue("rst out_res", 64'(out_res), 64'(0));
            checkValue("rst in_ready", 64'(in_ready), 64'(0));
        end
        rst = 1'b0;
        expQ.delete();
        held = 1'b0;
        #1;
        checkValue("post-rst in_ready", 64'(in_ready), 64'(1));
        checkValue("post-rst out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [36:0] expv);
        logic acc;
        applyStimulus(1'b1, a, b, op, 1'b1, acc);
        checkValue({tag, " accept"}, 64'(acc), 64'(1));
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
        checkValue(tag, 64'({out_res, out_zero, out_neg, out_carry, out_ovf, out_ill}), 64'(expv));
    endtask

    initial begin
        logic        acc;
        int          k;
        logic [31:0] bpA[4];
        logic [31:0] bpB[4];
        logic [3:0]  bpOp[4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        doReset(2);

        // Fill the buffer, then reset through it for three cycles.
        applyStimulus(1'b1, 32'd10, 32'd20, 4'b0010, 1'b0, acc);
        applyStimulus(1'b1, 32'd30, 32'd40, 4'b0010, 1'b0, acc);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, acc);
        doReset(3);

        // Directed corner cases; expected values are {res, zero, neg, carry, ovf, ill}.
        directed("add wrap",   32'hFFFF_FFFF, 32'h1, 4'b0010, {32'h0000_0000, 5'b10100});
        directed("add ovf",    32'h7FFF_FFFF, 32'h1, 4'b0010, {32'h8000_0000, 5'b01010});
        directed("sub borrow", 32'd5, 32'd7, 4'b0110, {32'hFFFF_FFFE, 5'b01000});
        directed("slt",        32'hFFFF_FFFF, 32'h1, 4'b0111, {32'h0000_0001, 5'b00000});
        directed("sltu",       32'hFFFF_FFFF, 32'h1, 4'b1000, {32'h0000_0000, 5'b10000});
        directed("illegal",    32'h1234, 32'h1234, 4'b1111, {32'h0000_0000, 5'b10001});
        directed("xor",        32'hF0F0, 32'h0FF0, 4'b0011, {32'h0000_FF00, 5'b00000});

        // Backpressure: four ops offered back to back while the consumer stalls.
        bpA  = '{32'd100, 32'd9, 32'hAAAA_0000, 32'h0F0F_0F0F};
        bpB  = '{32'd23, 32'd4, 32'h5555_FFFF, 32'hF000_0000};
        bpOp = '{4'b0010, 4'b0110, 4'b0011, 4'b0001};
        k = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b1, bpA[k], bpB[k], bpOp[k], 1'b0, acc);
            if (acc) k++;
        end
        checkValue("bp accepts", 64'(k), 64'(2));
        popCount = 0;
        for (int cyc = 0; cyc < 20 && (k < 4 || expQ.size() != 0); cyc++) begin
            applyStimulus(k < 4, bpA[k < 4 ? k : 0], bpB[k < 4 ? k : 0], bpOp[k < 4 ? k : 0], 1'b1, acc);
            if (acc) k++;
        end
        checkValue("bp drained", 64'(popCount), 64'(4));

        // Randomized traffic with random stalls on both sides.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(),
                          4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
        end
        for (int cyc = 0; cyc < 10 && expQ.size() != 0; cyc++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
        end
        checkValue("final drain", 64'(expQ.size()), 64'(0));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
